// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_VALID = 2'd2,
        S_FAULT = 2'd3
    } fetch_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Instruction-memory port plus the fetched-instruction handshake towards decode.
interface inst_fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic        inst_ready;

    modport master (
        output imem_req, imem_addr, inst_valid, inst,
        input  imem_gnt, imem_rvalid, imem_rdata, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst,
        output imem_gnt, imem_rvalid, imem_rdata, inst_ready
    );

endinterface

// File: rtl/inst_fetch_unit.sv
// Holds the architectural PC and fetches one instruction at a time from
// instruction memory, handing it to decode with a valid/ready handshake.
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               next_pc,
    output logic [31:0]               pc,
    inst_fetch_unit_if.master         bus,
    output logic                      fault,
    output logic [31:0]               retire_cnt
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q;
    logic [31:0]  inst_q;
    logic [31:0]  cnt_q;
    logic         capture;
    logic         retire;

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        retire  = 1'b0;
        case (state_q)
            S_FETCH: begin
                // A response without a grant belongs to a request from before reset.
                if (bus.imem_gnt) begin
                    if (bus.imem_rvalid) begin
                        capture = 1'b1;
                        state_d = S_VALID;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (bus.imem_rvalid) begin
                    capture = 1'b1;
                    state_d = S_VALID;
                end
            end
            S_VALID: begin
                if (bus.inst_ready) begin
                    retire  = 1'b1;
                    state_d = (next_pc[1:0] == 2'b00) ? S_FETCH : S_FAULT;
                end
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            inst_q  <= INST_NOP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                inst_q <= bus.imem_rdata;
            end
            // Misaligned targets are still loaded so the faulting PC is visible.
            if (retire) begin
                pc_q  <= next_pc;
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

    assign pc             = pc_q;
    assign bus.imem_addr  = pc_q;
    assign bus.imem_req   = (state_q == S_FETCH);
    assign bus.inst_valid = (state_q == S_VALID);
    assign bus.inst       = inst_q;
    assign fault          = (state_q == S_FAULT);
    assign retire_cnt     = cnt_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: reset, zero-wait and wait-state fetch,
// stall/retire, misaligned fault, reset mid-wait and counter wrap.
module tb_inst_fetch_unit;
    import fetch_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] next_pc;
    logic [31:0] pc;
    logic        fault;
    logic [31:0] retire_cnt;
    int          tests;
    int          failed;

    inst_fetch_unit_if bus ();

    inst_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .next_pc    (next_pc),
        .pc         (pc),
        .bus        (bus),
        .fault      (fault),
        .retire_cnt (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        rst = 1'b0;
        next_pc = 32'h0;
        bus.imem_gnt    = 1'b1;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h0040_0093;
        bus.inst_ready  = 1'b0;
        #1 rst = 1'b1;
        step();

        // Reset values
        check("rst_pc",     pc,                  32'h0);
        check("rst_addr",   bus.imem_addr,       32'h0);
        check("rst_req",    {31'b0, bus.imem_req},   32'd1);
        check("rst_valid",  {31'b0, bus.inst_valid}, 32'd0);
        check("rst_inst",   bus.inst,            32'h0000_0013);
        check("rst_fault",  {31'b0, fault},      32'd0);
        check("rst_cnt",    retire_cnt,          32'd0);

        // Zero-wait fetch
        rst = 1'b0;
        check("zw_addr_c0", bus.imem_addr, 32'h0);
        step();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        check("zw_valid_c1", {31'b0, bus.inst_valid}, 32'd1);
        check("zw_inst_c1",  bus.inst,                32'h0040_0093);

        // Stall three cycles, then retire to PC 4
        next_pc = 32'h0000_0004;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_valid", {31'b0, bus.inst_valid}, 32'd1);
            check("stall_inst",  bus.inst,                32'h0040_0093);
            check("stall_pc",    pc,                      32'h0);
        end
        bus.inst_ready = 1'b1;
        step();
        bus.inst_ready = 1'b0;
        check("ret_pc",    pc,                       32'h4);
        check("ret_addr",  bus.imem_addr,            32'h4);
        check("ret_cnt",   retire_cnt,               32'd1);
        check("ret_req",   {31'b0, bus.imem_req},    32'd1);
        check("ret_valid", {31'b0, bus.inst_valid},  32'd0);

        // Wait-state memory: gnt in cycle 0, rvalid in cycle 3
        bus.imem_gnt   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEE3;
        step();
        bus.imem_gnt = 1'b0;
        check("ws_req_c1", {31'b0, bus.imem_req}, 32'd0);
        bus.imem_gnt = 1'b1;
        step();
        bus.imem_gnt = 1'b0;
        check("ws_req_c2", {31'b0, bus.imem_req}, 32'd0);
        step();
        bus.imem_rvalid = 1'b1;
        check("ws_req_c3",   {31'b0, bus.imem_req},   32'd0);
        check("ws_valid_c3", {31'b0, bus.inst_valid}, 32'd0);
        step();
        bus.imem_rvalid = 1'b0;
        check("ws_valid_c4", {31'b0, bus.inst_valid}, 32'd1);
        check("ws_inst_c4",  bus.inst,                32'hDEAD_BEE3);

        // Misaligned next PC
        next_pc = 32'h0000_0006;
        bus.inst_ready = 1'b1;
        step();
        bus.inst_ready = 1'b0;
        check("mis_cnt", retire_cnt, 32'd2);
        for (int i = 0; i < 10; i++) begin
            bus.imem_gnt    = 1'b1;
            bus.imem_rvalid = 1'b1;
            check("mis_fault", {31'b0, fault},          32'd1);
            check("mis_pc",    pc,                      32'h6);
            check("mis_req",   {31'b0, bus.imem_req},   32'd0);
            check("mis_valid", {31'b0, bus.inst_valid}, 32'd0);
            step();
        end
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        rst = 1'b1;
        #1;
        check("flt_rst_fault", {31'b0, fault}, 32'd0);
        check("flt_rst_pc",    pc,             32'h0);
        step();
        rst = 1'b0;

        // Reset mid-wait, then a stale response
        bus.imem_gnt = 1'b1;
        step();
        bus.imem_gnt = 1'b0;
        check("mw_req_wait", {31'b0, bus.imem_req}, 32'd0);
        #2 rst = 1'b1;
        #1;
        check("mw_rst_pc",  pc,                    32'h0);
        check("mw_rst_req", {31'b0, bus.imem_req}, 32'd1);
        check("mw_rst_cnt", retire_cnt,            32'd0);
        step();
        rst = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h1111_1113;
        step();
        check("stale_valid", {31'b0, bus.inst_valid}, 32'd0);
        check("stale_req",   {31'b0, bus.imem_req},   32'd1);
        check("stale_inst",  bus.inst,                32'h0000_0013);
        bus.imem_rvalid = 1'b0;

        // inst_ready without a valid instruction has no effect
        bus.inst_ready = 1'b1;
        next_pc = 32'h0000_0040;
        step();
        bus.inst_ready = 1'b0;
        check("nv_pc",  pc,         32'h0);
        check("nv_cnt", retire_cnt, 32'd0);

        // Counter wrap
        bus.imem_gnt    = 1'b1;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h0000_0513;
        step();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        check("cw_valid", {31'b0, bus.inst_valid}, 32'd1);
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        #1;
        check("cw_preload", retire_cnt, 32'hFFFF_FFFF);
        next_pc = 32'h0000_0008;
        bus.inst_ready = 1'b1;
        step();
        bus.inst_ready = 1'b0;
        check("cw_cnt",   retire_cnt, 32'd0);
        check("cw_pc",    pc,         32'h8);
        check("cw_fault", {31'b0, fault}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
